// File: rtl/bpu_update_queue_if.sv
// rtl/bpu_update_queue_if.sv - fetch/execute facing signal bundle of the branch update queue
interface bpu_update_queue_if #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             alloc_valid;
    logic             alloc_ready;
    logic [31:0]      alloc_pc;
    logic             alloc_pred_taken;
    logic             resolve_valid;
    logic             resolve_taken;
    logic [31:0]      resolve_target;
    logic             flush;
    logic             update_valid;
    logic [31:0]      update_addr;
    logic             update_taken;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic [CW-1:0]    count;
    logic             resolve_err;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output alloc_valid, alloc_pc, alloc_pred_taken,
        output resolve_valid, resolve_taken, resolve_target, flush,
        input  alloc_ready, update_valid, update_addr, update_taken,
        input  redirect_valid, redirect_pc, count, resolve_err, branch_cnt, mispred_cnt
    );

    modport slave (
        input  alloc_valid, alloc_pc, alloc_pred_taken,
        input  resolve_valid, resolve_taken, resolve_target, flush,
        output alloc_ready, update_valid, update_addr, update_taken,
        output redirect_valid, redirect_pc, count, resolve_err, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/bpu_update_queue.sv
// rtl/bpu_update_queue.sv - in-order branch tracking queue producing predictor training and redirects
module bpu_update_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    bpu_update_queue_if.slave  q_if
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]      PTR_ONE = {{PW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      pc_mem [DEPTH];
    logic [DEPTH-1:0] pred_mem;

    logic [PW:0]      head_q, head_d, tail_q, tail_d;
    logic             upd_valid_q, upd_valid_d;
    logic [31:0]      upd_addr_q, upd_addr_d;
    logic             upd_taken_q, upd_taken_d;
    logic             redir_valid_q, redir_valid_d;
    logic [31:0]      redir_pc_q, redir_pc_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d, mcnt_q, mcnt_d;

    logic        full, empty, do_alloc, do_resolve, mispredict;
    logic [31:0] head_pc;
    logic        head_pred;

    assign empty      = (head_q == tail_q);
    assign full       = (head_q[PW] != tail_q[PW]) && (head_q[PW-1:0] == tail_q[PW-1:0]);
    assign head_pc    = pc_mem[head_q[PW-1:0]];
    assign head_pred  = pred_mem[head_q[PW-1:0]];
    assign do_resolve = q_if.resolve_valid && !empty && !q_if.flush;
    assign mispredict = do_resolve && (head_pred != q_if.resolve_taken);
    // Allocations arriving with a flush or a mispredict are wrong-path and dropped.
    assign do_alloc   = q_if.alloc_valid && !full && !q_if.flush && !mispredict;

    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        upd_valid_d   = 1'b0;
        upd_addr_d    = upd_addr_q;
        upd_taken_d   = upd_taken_q;
        redir_valid_d = 1'b0;
        redir_pc_d    = redir_pc_q;
        err_d         = err_q;
        bcnt_d        = bcnt_q;
        mcnt_d        = mcnt_q;

        if (do_alloc) begin
            tail_d = tail_q + PTR_ONE;
        end
        if (do_resolve) begin
            head_d      = head_q + PTR_ONE;
            upd_valid_d = 1'b1;
            upd_addr_d  = head_pc;
            upd_taken_d = q_if.resolve_taken;
            bcnt_d      = (bcnt_q == '1) ? bcnt_q : bcnt_q + CNT_ONE;
        end
        if (mispredict) begin
            redir_valid_d = 1'b1;
            redir_pc_d    = q_if.resolve_taken ? q_if.resolve_target : head_pc + 32'd4;
            mcnt_d        = (mcnt_q == '1) ? mcnt_q : mcnt_q + CNT_ONE;
        end
        if (q_if.flush || mispredict) begin
            head_d = tail_q;
            tail_d = tail_q;
        end
        if (q_if.resolve_valid && empty && !q_if.flush) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q        <= '0;
            tail_q        <= '0;
            upd_valid_q   <= 1'b0;
            upd_addr_q    <= '0;
            upd_taken_q   <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            err_q         <= 1'b0;
            bcnt_q        <= '0;
            mcnt_q        <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            upd_valid_q   <= upd_valid_d;
            upd_addr_q    <= upd_addr_d;
            upd_taken_q   <= upd_taken_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            err_q         <= err_d;
            bcnt_q        <= bcnt_d;
            mcnt_q        <= mcnt_d;
        end
    end

    // Entry payload needs no reset: validity is defined solely by the pointers.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            pc_mem[tail_q[PW-1:0]]   <= q_if.alloc_pc;
            pred_mem[tail_q[PW-1:0]] <= q_if.alloc_pred_taken;
        end
    end

    assign q_if.alloc_ready    = !full;
    assign q_if.count          = tail_q - head_q;
    assign q_if.update_valid   = upd_valid_q;
    assign q_if.update_addr    = upd_addr_q;
    assign q_if.update_taken   = upd_taken_q;
    assign q_if.redirect_valid = redir_valid_q;
    assign q_if.redirect_pc    = redir_pc_q;
    assign q_if.resolve_err    = err_q;
    assign q_if.branch_cnt     = bcnt_q;
    assign q_if.mispred_cnt    = mcnt_q;
endmodule

// File: tb/tb_bpu_update_queue.sv
// tb/tb_bpu_update_queue.sv - vector table plus queue-model scoreboard for bpu_update_queue
module tb_bpu_update_queue;
    localparam int DEPTH   = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;

    bpu_update_queue_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    bpu_update_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q_if  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        taken;
        logic        redir;
        logic [31:0] rpc;
    } exp_t;

    typedef struct {
        logic        av;
        logic [31:0] apc;
        logic        ap;
        logic        rv;
        logic        rt;
        logic [31:0] rtg;
        logic        fl;
        int          exp_count;
        logic        exp_redir;
        logic [31:0] exp_rpc;
    } vec_t;

    logic [32:0] mq[$];
    exp_t        exp_q[$];
    int          bcnt, mcnt;
    logic        merr;
    int          n_checks, n_errors;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        bcnt = 0;
        mcnt = 0;
        merr = 1'b0;
    endtask

    task automatic check_outputs();
        exp_t x;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("update_valid", 32'(bus.update_valid), 32'd1);
            chk("update_addr", bus.update_addr, x.addr);
            chk("update_taken", 32'(bus.update_taken), 32'(x.taken));
            chk("redirect_valid", 32'(bus.redirect_valid), 32'(x.redir));
            if (x.redir) chk("redirect_pc", bus.redirect_pc, x.rpc);
        end else begin
            chk("update_idle", 32'(bus.update_valid), 32'd0);
            chk("redirect_idle", 32'(bus.redirect_valid), 32'd0);
        end
        chk("count", 32'(bus.count), 32'(mq.size()));
        chk("resolve_err", 32'(bus.resolve_err), 32'(merr));
        chk("branch_cnt", 32'(bus.branch_cnt), 32'(bcnt));
        chk("mispred_cnt", 32'(bus.mispred_cnt), 32'(mcnt));
    endtask

    task automatic drive_cycle(input logic av, input logic [31:0] apc, input logic ap,
                               input logic rv, input logic rt, input logic [31:0] rtg,
                               input logic fl);
        logic [32:0] e;
        exp_t        x;
        logic        full_b, acc, mis;
        bus.alloc_valid      = av;
        bus.alloc_pc         = apc;
        bus.alloc_pred_taken = ap;
        bus.resolve_valid    = rv;
        bus.resolve_taken    = rt;
        bus.resolve_target   = rtg;
        bus.flush            = fl;
        full_b = (mq.size() == DEPTH);
        chk("alloc_ready", 32'(bus.alloc_ready), 32'(!full_b));
        acc = av && !full_b;
        mis = 1'b0;
        if (fl) begin
            mq.delete();
        end else if (rv) begin
            if (mq.size() == 0) begin
                merr = 1'b1;
            end else begin
                e       = mq.pop_front();
                mis     = (e[32] != rt);
                x.addr  = e[31:0];
                x.taken = rt;
                x.redir = mis;
                x.rpc   = rt ? rtg : e[31:0] + 32'd4;
                exp_q.push_back(x);
                if (bcnt < CNT_MAX) bcnt++;
                if (mis && mcnt < CNT_MAX) mcnt++;
                if (mis) mq.delete();
            end
        end
        if (acc && !fl && !mis) mq.push_back({ap, apc});
        @(posedge clk);
        #1;
        bus.alloc_valid   = 1'b0;
        bus.resolve_valid = 1'b0;
        bus.flush         = 1'b0;
        check_outputs();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_update_valid"}, 32'(bus.update_valid), 32'd0);
        chk({tag, "_update_addr"}, bus.update_addr, 32'd0);
        chk({tag, "_update_taken"}, 32'(bus.update_taken), 32'd0);
        chk({tag, "_redirect_valid"}, 32'(bus.redirect_valid), 32'd0);
        chk({tag, "_redirect_pc"}, bus.redirect_pc, 32'd0);
        chk({tag, "_count"}, 32'(bus.count), 32'd0);
        chk({tag, "_resolve_err"}, 32'(bus.resolve_err), 32'd0);
        chk({tag, "_branch_cnt"}, 32'(bus.branch_cnt), 32'd0);
        chk({tag, "_mispred_cnt"}, 32'(bus.mispred_cnt), 32'd0);
        chk({tag, "_alloc_ready"}, 32'(bus.alloc_ready), 32'd1);
    endtask

    vec_t vecs[15];

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        //          av  apc           ap  rv  rt  rtg           fl  cnt redir rpc
        vecs[0]  = '{1, 32'h100,      1,  0,  0,  32'h0,        0,  1,  0, 32'h0};
        vecs[1]  = '{0, 32'h0,        0,  1,  1,  32'h200,      0,  0,  0, 32'h0};
        vecs[2]  = '{1, 32'h100,      0,  0,  0,  32'h0,        0,  1,  0, 32'h0};
        vecs[3]  = '{1, 32'h104,      0,  0,  0,  32'h0,        0,  2,  0, 32'h0};
        vecs[4]  = '{1, 32'h108,      0,  0,  0,  32'h0,        0,  3,  0, 32'h0};
        vecs[5]  = '{1, 32'h10C,      0,  1,  1,  32'h400,      0,  0,  1, 32'h400};
        vecs[6]  = '{1, 32'h300,      1,  0,  0,  32'h0,        0,  1,  0, 32'h0};
        vecs[7]  = '{0, 32'h0,        0,  1,  0,  32'h777,      0,  0,  1, 32'h304};
        vecs[8]  = '{1, 32'hFFFFFFFC, 1,  0,  0,  32'h0,        0,  1,  0, 32'h0};
        vecs[9]  = '{0, 32'h0,        0,  1,  0,  32'h888,      0,  0,  1, 32'h0};
        vecs[10] = '{0, 32'h0,        0,  1,  1,  32'h999,      0,  0,  0, 32'h0};
        vecs[11] = '{1, 32'h500,      1,  0,  0,  32'h0,        0,  1,  0, 32'h0};
        vecs[12] = '{1, 32'h504,      1,  0,  0,  32'h0,        0,  2,  0, 32'h0};
        vecs[13] = '{1, 32'h508,      1,  0,  0,  32'h0,        0,  3,  0, 32'h0};
        vecs[14] = '{1, 32'h50C,      1,  1,  1,  32'h0,        1,  0,  0, 32'h0};

        rst_n                = 1'b0;
        bus.alloc_valid      = 1'b0;
        bus.alloc_pc         = '0;
        bus.alloc_pred_taken = 1'b0;
        bus.resolve_valid    = 1'b0;
        bus.resolve_taken    = 1'b0;
        bus.resolve_target   = '0;
        bus.flush            = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive_cycle(vecs[i].av, vecs[i].apc, vecs[i].ap, vecs[i].rv,
                        vecs[i].rt, vecs[i].rtg, vecs[i].fl);
            chk($sformatf("tbl%0d_count", i), 32'(bus.count), 32'(vecs[i].exp_count));
            chk($sformatf("tbl%0d_redir", i), 32'(bus.redirect_valid), 32'(vecs[i].exp_redir));
            if (vecs[i].exp_redir) chk($sformatf("tbl%0d_rpc", i), bus.redirect_pc, vecs[i].exp_rpc);
        end
        chk("err_sticky", 32'(bus.resolve_err), 32'd1);
        chk("branch_after_table", 32'(bus.branch_cnt), 32'd4);
        chk("mispred_after_table", 32'(bus.mispred_cnt), 32'd3);

        for (int i = 0; i < DEPTH; i++)
            drive_cycle(1'b1, 32'h1000 + 32'(4 * i), i[0], 1'b0, 1'b0, 32'h0, 1'b0);
        chk("full_ready", 32'(bus.alloc_ready), 32'd0);
        drive_cycle(1'b1, 32'h2000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("ninth_dropped", 32'(bus.count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++)
            drive_cycle(i == 0, 32'h3000, 1'b0, 1'b1, i[0], 32'h0, 1'b0);
        chk("drained", 32'(bus.count), 32'd0);

        for (int i = 0; i < DEPTH; i++)
            drive_cycle(1'b1, 32'h4000 + 32'(4 * i), 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("refill_count", 32'(bus.count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++)
            drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b1, 32'h6000 + 32'(4 * i), 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0);
        end
        chk("branch_saturated", 32'(bus.branch_cnt), 32'(CNT_MAX));
        chk("mispred_held", 32'(bus.mispred_cnt), 32'd3);

        drive_cycle(1'b1, 32'h700, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        drive_cycle(1'b1, 32'h704, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bpu_update_queue.md
Name: bpu_update_queue

Overview:
- Tracks every conditional branch the fetch stage predicts, in program order, from prediction until execute resolves it.
- On each in-order resolution it produces the training write-back for the branch predictor (update_valid / update_addr / update_taken) and detects mispredictions.
- On a misprediction it issues a fetch redirect and discards all younger wrong-path entries.
- Sits between fetch (allocation side) and execute (resolution side).

Parameters:
- DEPTH, 8, number of in-flight branch entries; power of two, >= 2.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- alloc_valid  in  1  fetch presents a predicted branch.
- alloc_ready  out  1  entry available (= !full); an allocation is accepted when alloc_valid && alloc_ready.
- alloc_pc  in  32  branch instruction address.
- alloc_pred_taken  in  1  direction predicted by the predictor.
- resolve_valid  in  1  execute resolves the oldest branch this cycle.
- resolve_taken  in  1  actual direction.
- resolve_target  in  32  actual taken target.
- flush  in  1  external pipeline flush (exception/trap); clears all entries.
- update_valid  out  1  predictor training pulse.
- update_addr  out  32  PC of the resolved branch.
- update_taken  out  1  actual direction.
- redirect_valid  out  1  misprediction redirect pulse.
- redirect_pc  out  32  correct fetch address.
- count  out  $clog2(DEPTH)+1  current occupancy.
- resolve_err  out  1  sticky: a resolve arrived while the queue was empty.
- branch_cnt  out  CNT_W  resolved branches, saturating.
- mispred_cnt  out  CNT_W  mispredictions, saturating.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Entries invalid; head = tail = count = 0.
  - All outputs 0, including all counters and resolve_err.
- Storage: circular buffer of {pc, pred_taken}. Head and tail pointers carry one extra wrap bit.
  - full when pointers are equal except the wrap bit; empty when the pointers are identical.
- Allocation:
  - Accepted on the edge where alloc_valid && alloc_ready; tail advances and wraps modulo DEPTH.
  - alloc_ready depends only on full, never on a same-cycle resolve (no combinational path from resolve_valid).
- Resolution (resolve_valid && !empty && !flush): the head entry pops at the edge. Registered outputs are visible in cycle N+1 and last exactly one cycle:
  - update_valid = 1, update_addr = head pc, update_taken = resolve_taken.
  - Mispredict = (head pred_taken != resolve_taken).
    - If mispredict: redirect_valid = 1; redirect_pc = resolve_target when taken, otherwise head pc + 4 (32-bit wrap-around).
  - branch_cnt increments. mispred_cnt increments on a mispredict. Both saturate at all-ones.
- Mispredict flush:
  - On the same edge that pops a mispredicted head, all remaining entries are discarded; head = tail, count = 0.
  - An allocation presented in that same cycle is dropped, because it is wrong-path.
- External flush:
  - Clears the queue at the edge. Any same-cycle alloc is dropped.
  - flush wins over a same-cycle resolve: no update, no redirect, no counter change.
- Resolve when empty (and no flush): ignored and no pop; resolve_err sets and stays set until reset.
- Simultaneous alloc and resolve with no mispredict: both take effect and count is unchanged. This is legal even when full, because alloc_ready was 0, so no alloc is accepted.
- Outputs not pulsing hold 0 for update_valid and redirect_valid. update_addr, update_taken and redirect_pc hold their last values.
- Reset asserted mid-operation: all state clears immediately, including any pulse in flight.

Test Plan:
- Reset, then alloc pc=0x100 pred=1; resolve taken=1, target=0x200 -> next cycle update_valid=1, addr=0x100, taken=1; redirect_valid=0; count=0; branch_cnt=1.
- Alloc 0x100 (pred=0), 0x104, 0x108; resolve taken=1, target=0x400 -> redirect_valid=1, redirect_pc=0x400, update_taken=1, count=0, mispred_cnt=1; a same-cycle alloc of 0x10C is not retained.
- Alloc 0x300 pred=1; resolve taken=0 -> redirect_pc=0x304. Repeat with pc=0xFFFFFFFC -> redirect_pc=0x00000000.
- Fill DEPTH=8 entries -> alloc_ready=0 and a 9th alloc is ignored. Resolve 8 correct predictions -> 8 update pulses with PCs in allocation order; the pointers wrap cleanly on a second fill.
- Resolve on an empty queue -> no pulses, resolve_err=1 and it remains 1. flush together with resolve on a 3-entry queue -> count=0, no update, branch_cnt unchanged.
- Preload branch_cnt near saturation (or run with CNT_W=4) and issue 20 resolves -> branch_cnt holds at 0xF. Drop rst_n mid-stream -> all outputs 0 asynchronously.
